// File: rtl/interval_capture.sv
// rtl/interval_capture.sv - cycle-interval measurement between a start and a stop event
// Counts edges from Start_i to Stop_i; the result saturates at all-ones and flags overflow.
module interval_capture #(
   parameter int WIDTH = 8
) (
   input  logic             Clk_i,
   input  logic             Rst_ni,
   input  logic             Start_i,
   input  logic             Stop_i,
   output logic [WIDTH-1:0] Time_o,
   output logic             Valid_o,
   output logic             Ovf_o,
   output logic             Busy_o
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             sat_q, sat_d;
   logic [WIDTH-1:0] time_q, time_d;
   logic             valid_q, valid_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;

   always_ff @(posedge Clk_i or negedge Rst_ni) begin
      if (!Rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
         time_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
         time_q  <= time_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sat_d   = sat_q;
      time_d  = time_q;
      valid_d = 1'b0;
      ovf_d   = ovf_q;

      case (state_q)
         IDLE: begin
            // A stop on the same edge as the start is not a measurement.
            if (Start_i) begin
               cnt_d   = CNT_ONE;
               sat_d   = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (Stop_i) begin
               time_d  = cnt_q;
               ovf_d   = sat_q;
               valid_d = 1'b1;
               if (Start_i) begin
                  cnt_d = CNT_ONE;
                  sat_d = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end else if (Start_i) begin
               cnt_d = CNT_ONE;
               sat_d = 1'b0;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_ONE;
            end else begin
               sat_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == RUN);
   end

   assign Time_o  = time_q;
   assign Valid_o = valid_q;
   assign Ovf_o   = ovf_q;
   assign Busy_o  = busy_q;

endmodule

// File: doc/interval_capture.md
# interval_capture

Cycle-interval measurement block, the inverse of the controller's countdown timer. The timer turns a loaded count into a delayed one-cycle pulse; this block turns the delay between a start event and a stop event back into a count. It sits beside the FSM controller to measure sensor pulse widths and periods, and in loopback to check the timer's programmed delays.

## Interface

- WIDTH, default 8: width of the interval counter and of Time_o. The maximum measurable value is 2^WIDTH-1.

- Clk_i  input  1  system clock; all state changes on the rising edge.
- Rst_ni  input  1  reset, active-low, asynchronous assert, synchronous release.
- Start_i  input  1  start or restart a measurement; level sampled each edge.
- Stop_i  input  1  end the measurement; level sampled each edge.
- Time_o  output  WIDTH  last captured interval, in cycles; held until the next capture.
- Valid_o  output  1  one-cycle pulse when Time_o and Ovf_o are updated.
- Ovf_o  output  1  the last capture saturated; qualifies Time_o and is held with it.
- Busy_o  output  1  a measurement is in progress (state RUN).

## Operation

- Two states: IDLE and RUN. Internal registers: counter cnt (WIDTH bits) and saturation flag sat.
- Reset, at any time including mid-run:
  - state goes to IDLE;
  - cnt, sat, Time_o, Valid_o, Ovf_o and Busy_o all go to 0.
- IDLE:
  - Start_i=1: cnt<=1, sat<=0, go to RUN. Start_i wins if Stop_i is also 1.
  - Stop_i=1 alone: ignored.
- RUN, with Start_i=0 and Stop_i=0:
  - if cnt < 2^WIDTH-1: cnt<=cnt+1;
  - otherwise cnt holds at all-ones and sat<=1.
- RUN, with Stop_i=1 and Start_i=0:
  - Time_o<=cnt, Ovf_o<=sat, Valid_o<=1, go to IDLE.
- RUN, with Start_i=1 and Stop_i=1 (back-to-back period mode):
  - capture as in the stop case;
  - then cnt<=1, sat<=0, stay in RUN.
- RUN, with Start_i=1 and Stop_i=0:
  - restart: cnt<=1, sat<=0, stay in RUN;
  - no capture, Valid_o stays 0.
- Valid_o is 0 on every edge that does not capture.
- Busy_o = (state==RUN), registered.
- Arithmetic: unsigned; the increment saturates and never wraps to 0.

## Timing

- Measured value: if Start_i is sampled at edge t and Stop_i at edge t+N (N>=1), then Time_o = N. This holds for N <= 2^WIDTH-1; beyond that Time_o = 2^WIDTH-1 and Ovf_o = 1.
- Timer pairing: a timer triggered at edge t with load value N drives its timeout pulse high during the cycle after edge t+N-1. That pulse is sampled here at edge t+N, so feeding Start_i from the timer trigger and Stop_i from the timer timeout yields Time_o = N.
- Capture latency: Time_o, Ovf_o and Valid_o change at the edge that samples Stop_i and are visible in the cycle that follows.
- Valid_o is exactly one cycle wide; a new capture can follow on the very next edge.
- Busy_o rises after the Start edge. It falls after the Stop edge, except in period mode, where it stays high.
- Inputs are synchronous to Clk_i; no internal synchronizers.
- Minimum interval is 1. A stop on the same edge as the start from IDLE is not a measurement.

## Test plan

- Basic measurement: reset, Start_i pulse at edge 10, Stop_i pulse at edge 15 -> Time_o=5, Valid_o high for one cycle after edge 15, Ovf_o=0, Busy_o high from after edge 10 to after edge 15.
- Minimum interval: Start_i at edge t, Stop_i at edge t+1 -> Time_o=1. Also, Start_i and Stop_i together in IDLE -> no capture, Busy_o=1.
- Timer loopback: drive the timer with Time_i=7, connect its trigger to Start_i and its timeout to Stop_i -> Time_o=7. Repeat with Time_i=1 (expect 1) and Time_i=2^WIDTH-1 (expect 2^WIDTH-1 with Ovf_o=0).
- Saturation, WIDTH=4: Start_i, then Stop_i 20 cycles later -> Time_o=15, Ovf_o=1. A following 3-cycle run -> Time_o=3, Ovf_o=0.
- Period mode: Start_i at edge 0, then Start_i=Stop_i=1 at edge 3, then Stop_i at edge 7 -> captures 3 then 4, two Valid_o pulses, Busy_o low only after edge 7.
- Disturbances:
  - Rst_ni low mid-run (cnt=6) -> all outputs 0 immediately, state IDLE.
  - Stop_i in IDLE -> no Valid_o pulse.
  - Start_i alone mid-run -> restart with no capture; the next stop measures from the restart.
